// File: rtl/sdft_pkg.sv
// sdft_pkg: shared state encoding, Q-format helpers and saturation
// for the sequential sliding DFT. Twiddles are generated at elaboration.
package sdft_pkg;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_DELTA,
    S_UPDATE,
    S_DONE
  } state_t;

  localparam longint PI_Q28 = 64'sd843314857;

  function automatic int tw_frac(input int tw_w);
    return tw_w - 2;
  endfunction

  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Taylor series in Q28 on an angle folded into [-pi, pi]
  function automatic longint tw_q28(
    input int k,
    input int n,
    input bit want_sin
  );
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint d;
    int     kk;
    kk   = (2 * k > n) ? k - n : k;
    x    = (longint'(2) * PI_Q28 * longint'(kk)) / longint'(n);
    x2   = (x * x) >>> 28;
    term = want_sin ? x : (64'sd1 <<< 28);
    acc  = term;
    for (int i = 1; i < 16; i++) begin
      d = want_sin ? longint'((2 * i) * (2 * i + 1))
                   : longint'((2 * i - 1) * (2 * i));
      term = -((term * x2) >>> 28) / d;
      acc  = acc + term;
    end
    return acc;
  endfunction

  function automatic logic signed [31:0] twiddle(
    input int k,
    input int n,
    input int frac,
    input bit want_sin
  );
    longint v;
    v = tw_q28(k, n, want_sin);
    v = (v + (64'sd1 <<< (27 - frac))) >>> (28 - frac);
    return 32'(v);
  endfunction

endpackage

// File: rtl/sdft_cmac.sv
// sdft_cmac: combinational complex rotate of one bin by its twiddle,
// arithmetic shift back to the accumulator scale, saturate, clip flag.
module sdft_cmac
  import sdft_pkg::*;
#(
  parameter int ACC_W = 18,
  parameter int TW_W  = 16
) (
  input  logic signed [ACC_W:0]   a_re,
  input  logic signed [ACC_W-1:0] a_im,
  input  logic signed [TW_W-1:0]  tw_cos,
  input  logic signed [TW_W-1:0]  tw_sin,
  output logic signed [ACC_W-1:0] y_re,
  output logic signed [ACC_W-1:0] y_im,
  output logic                    clip
);

  localparam int PW   = ACC_W + TW_W + 2;
  localparam int FRAC = tw_frac(TW_W);

  logic signed [PW-1:0] p_ac, p_bs, p_as, p_bc;
  logic signed [PW-1:0] s_re, s_im;
  logic signed [63:0]   w_re, w_im, q_re, q_im;

  always_comb begin
    p_ac = PW'(a_re) * PW'(tw_cos);
    p_bs = PW'(a_im) * PW'(tw_sin);
    p_as = PW'(a_re) * PW'(tw_sin);
    p_bc = PW'(a_im) * PW'(tw_cos);
    s_re = (p_ac - p_bs) >>> FRAC;
    s_im = (p_as + p_bc) >>> FRAC;
    w_re = 64'(s_re);
    w_im = 64'(s_im);
    q_re = saturate(w_re, ACC_W);
    q_im = saturate(w_im, ACC_W);
    y_re = q_re[ACC_W-1:0];
    y_im = q_im[ACC_W-1:0];
    clip = (q_re != w_re) || (q_im != w_im);
  end

endmodule

// File: rtl/sdft_seq.sv
// sdft_seq: time-multiplexed sliding DFT, one bin per cycle through a
// shared complex multiplier, with a registered bin read port.
module sdft_seq
  import sdft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 18,
  parameter int TW_W   = 16,
  parameter int BINS   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_sample,
  input  logic [$clog2(BINS)-1:0]  rd_addr,
  output logic [ACC_W-1:0]         rd_real,
  output logic [ACC_W-1:0]         rd_imag,
  output logic                     frame_done,
  output logic                     sat
);

  localparam int            AW   = $clog2(BINS);
  localparam logic [AW-1:0] LAST = AW'(BINS - 1);

  state_t state, state_n;

  logic [AW-1:0]            cnt, ptr;
  logic signed [DATA_W-1:0] sample_q;
  logic signed [DATA_W:0]   delta;
  logic                     sticky, last, clip, rd_ok;
  logic signed [ACC_W:0]    a_re;
  logic signed [ACC_W-1:0]  y_re, y_im;

  logic signed [DATA_W-1:0] hist   [BINS];
  logic signed [ACC_W-1:0]  bin_re [BINS];
  logic signed [ACC_W-1:0]  bin_im [BINS];
  logic signed [TW_W-1:0]   cos_rom [BINS];
  logic signed [TW_W-1:0]   sin_rom [BINS];

  for (genvar g = 0; g < BINS; g++) begin : g_rom
    localparam logic signed [31:0] C =
      twiddle(g, BINS, tw_frac(TW_W), 1'b0);
    localparam logic signed [31:0] S =
      twiddle(g, BINS, tw_frac(TW_W), 1'b1);
    assign cos_rom[g] = TW_W'(C);
    assign sin_rom[g] = TW_W'(S);
  end

  assign last       = (cnt == LAST);
  assign in_ready   = (state == S_IDLE);
  assign frame_done = (state == S_DONE);
  assign sat        = frame_done && sticky;
  assign rd_ok      = {1'b0, rd_addr} < (AW + 1)'(BINS);
  assign a_re       = (ACC_W + 1)'(bin_re[cnt]) + (ACC_W + 1)'(delta);

  sdft_cmac #(
    .ACC_W (ACC_W),
    .TW_W  (TW_W)
  ) u_cmac (
    .a_re   (a_re),
    .a_im   (bin_im[cnt]),
    .tw_cos (cos_rom[cnt]),
    .tw_sin (sin_rom[cnt]),
    .y_re   (y_re),
    .y_im   (y_im),
    .clip   (clip)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_CLEAR;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_CLEAR:  if (last) state_n = S_IDLE;
      S_IDLE:   if (in_valid) state_n = S_DELTA;
      S_DELTA:  state_n = S_UPDATE;
      S_UPDATE: if (last) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_CLEAR;
    endcase
    if (clear) state_n = S_CLEAR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      ptr      <= '0;
      sample_q <= '0;
      delta    <= '0;
      sticky   <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      sticky <= 1'b0;
    end else begin
      unique case (state)
        S_CLEAR: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) ptr <= '0;
        end
        S_IDLE: if (in_valid) sample_q <= in_sample;
        S_DELTA: begin
          delta <= (DATA_W + 1)'(sample_q) - (DATA_W + 1)'(hist[ptr]);
          ptr   <= (ptr == LAST) ? '0 : ptr + 1'b1;
          cnt   <= '0;
        end
        S_UPDATE: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (clip) sticky <= 1'b1;
        end
        S_DONE:  sticky <= 1'b0;
        default: ;
      endcase
    end
  end

  // storage arrays carry no reset; CLEAR zeroes them
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (state == S_CLEAR) begin
        hist[cnt]   <= '0;
        bin_re[cnt] <= '0;
        bin_im[cnt] <= '0;
      end
      if (state == S_DELTA) hist[ptr] <= sample_q;
      if (state == S_UPDATE) begin
        bin_re[cnt] <= y_re;
        bin_im[cnt] <= y_im;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_real <= '0;
      rd_imag <= '0;
    end else begin
      rd_real <= rd_ok ? bin_re[rd_addr] : '0;
      rd_imag <= rd_ok ? bin_im[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_sdft_seq.sv
// tb_sdft_seq: randomized bench for sdft_seq (BINS=8) against a
// floating-point-twiddle sliding-DFT model.
module tb_sdft_seq;

  localparam int  DW = 16;
  localparam int  AC = 18;
  localparam int  TW = 16;
  localparam int  NB = 8;
  localparam int  AB = $clog2(NB);
  localparam real PI = 3.14159265358979;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_sample = '0;
  logic [AB-1:0] rd_addr = '0;
  logic [AC-1:0] rd_real, rd_imag;
  logic          frame_done, sat;

  int     n_chk = 0;
  int     n_err = 0;
  longint m_hist [NB];
  longint m_re   [NB];
  longint m_im   [NB];
  longint tw_c   [NB];
  longint tw_s   [NB];
  int     m_ptr;

  sdft_seq #(
    .DATA_W (DW),
    .ACC_W  (AC),
    .TW_W   (TW),
    .BINS   (NB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .rd_addr    (rd_addr),
    .rd_real    (rd_real),
    .rd_imag    (rd_imag),
    .frame_done (frame_done),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [AC-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint clamp(input longint v, inout bit c);
    longint hi = (longint'(1) <<< (AC - 1)) - 1;
    longint lo = -hi - 1;
    if (v > hi) begin c = 1'b1; return hi; end
    if (v < lo) begin c = 1'b1; return lo; end
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NB; k++) begin
      m_hist[k] = 0;
      m_re[k]   = 0;
      m_im[k]   = 0;
    end
    m_ptr = 0;
  endtask

  task automatic model_frame(input longint s, output bit c);
    longint d, a, r, i;
    c = 1'b0;
    d = s - m_hist[m_ptr];
    m_hist[m_ptr] = s;
    m_ptr = (m_ptr + 1) % NB;
    for (int k = 0; k < NB; k++) begin
      a = m_re[k] + d;
      r = (a * tw_c[k] - m_im[k] * tw_s[k]) >>> (TW - 2);
      i = (a * tw_s[k] + m_im[k] * tw_c[k]) >>> (TW - 2);
      m_re[k] = clamp(r, c);
      m_im[k] = clamp(i, c);
    end
  endtask

  task automatic accept(input longint s);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait", longint'(t < 40), 1);
    in_valid  = 1'b1;
    in_sample = DW'(s);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_sample = DW'($urandom);
  endtask

  task automatic wait_frame(input bit exp_sat, input string tag,
                            input int start);
    int lat = start;
    while (lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      in_sample = DW'($urandom);
      if (frame_done) break;
    end
    check({tag, "_lat"}, lat, NB + 1);
    check({tag, "_sat"}, sat, exp_sat);
  endtask

  task automatic send(input longint s, input string tag);
    bit c;
    model_frame(s, c);
    accept(s);
    wait_frame(c, tag, 0);
  endtask

  task automatic read_bin(input int k, output longint re,
                          output longint im);
    @(negedge clk);
    rd_addr = AB'(k);
    @(posedge clk);
    #1;
    re = sx(rd_real);
    im = sx(rd_imag);
  endtask

  task automatic check_all(input string tag);
    longint re, im;
    for (int k = 0; k < NB; k++) begin
      read_bin(k, re, im);
      check($sformatf("%s_re%0d", tag, k), re, m_re[k]);
      check($sformatf("%s_im%0d", tag, k), im, m_im[k]);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    int fd = 0;
    while (n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (frame_done) fd++;
      if (in_ready) break;
    end
    check({tag, "_len"}, n, NB);
    check({tag, "_fd"}, fd, 0);
  endtask

  initial begin
    longint re, im, s, old_re3, old_im3;
    int     nacc, last_acc;
    bit     hs, c;

    for (int k = 0; k < NB; k++) begin
      tw_c[k] = longint'($rtoi($floor(
        $cos(2.0 * PI * k / NB) * 16384.0 + 0.5)));
      tw_s[k] = longint'($rtoi($floor(
        $sin(2.0 * PI * k / NB) * 16384.0 + 0.5)));
    end
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_fd", frame_done, 0);
    check("rst_sat", sat, 0);
    check("rst_re", sx(rd_real), 0);
    check("rst_im", sx(rd_imag), 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready("init");
    check_all("init");

    send(100, "imp");
    read_bin(0, re, im);
    check("imp_b0re", re, 100);
    check("imp_b0im", im, 0);
    read_bin(2, re, im);
    check("imp_b2re", re, 0);
    check("imp_b2im", im, 100);
    check_all("imp");

    send(0, "z1");
    read_bin(2, re, im);
    check("z1_b2re", re, -100);
    check("z1_b2im", im, 0);
    for (int i = 2; i <= NB; i++) send(0, $sformatf("z%0d", i));
    read_bin(0, re, im);
    check("win_b0re", re, 0);
    check("win_b0im", im, 0);
    check_all("win");

    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) s = longint'($urandom_range(65535)) - 32768;
      else            s = longint'($urandom_range(4000)) - 2000;
      send(s, $sformatf("rnd%0d", i));
    end
    check_all("rnd");

    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
    wait_ready("clr");
    check_all("clr");

    for (int i = 1; i <= NB; i++) begin
      send(32767, $sformatf("sat%0d", i));
      read_bin(0, re, im);
      check($sformatf("sat%0d_b0", i), re, m_re[0]);
      if (i >= 5) check($sformatf("sat%0d_clip", i), re, 131071);
    end

    accept(1234);
    repeat (3) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
    wait_ready("clrmid");
    check_all("clrmid");

    nacc     = 0;
    last_acc = -1;
    c        = 1'b0;
    old_re3  = 0;
    old_im3  = 0;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 100 && nacc < 4; cyc++) begin
      @(negedge clk);
      in_sample = DW'($urandom);
      hs = in_ready;
      s  = longint'($signed(in_sample));
      @(posedge clk);
      #1;
      if (hs) begin
        nacc++;
        if (last_acc >= 0) check("bp_gap", cyc - last_acc, NB + 3);
        last_acc = cyc;
        if (nacc == 4) begin
          in_valid = 1'b0;
          old_re3  = m_re[3];
          old_im3  = m_im[3];
        end
        model_frame(s, c);
      end
    end
    check("bp_cnt", nacc, 4);
    rd_addr = AB'(3);
    repeat (5) @(posedge clk);
    #1;
    check("bp_old_re", sx(rd_real), old_re3);
    check("bp_old_im", sx(rd_imag), old_im3);
    @(posedge clk);
    #1;
    check("bp_new_re", sx(rd_real), m_re[3]);
    check("bp_new_im", sx(rd_imag), m_im[3]);
    wait_frame(c, "bp", 6);
    check_all("bp");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
